// File: rtl/lsu_ctrl.sv
// Load/store unit controller: issues one memory request per accepted op,
// waits for the acknowledge with a bounded timeout, then writes back to the register file.
module lsu_ctrl #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    input  logic       op_store,
    input  logic       op_ptr_update,
    input  logic [7:0] op_ptr_delta,
    input  logic [7:0] addr_lo,
    input  logic [7:0] addr_hi,
    input  logic [7:0] store_data,
    output logic       op_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       rf_write_en,
    output logic       rf_add,
    output logic [7:0] rf_din,
    output logic [7:0] rf_constant,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t     state;
    logic       store_q;
    logic       upd_q;
    logic [7:0] delta_q;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;

    assign wait_next = wait_cnt + 8'd1;

    // The memory request fields are loaded only at accept, so they stay frozen while the op is outstanding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_ready    <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 16'd0;
            mem_wdata   <= 8'd0;
            rf_write_en <= 1'b0;
            rf_add      <= 1'b0;
            rf_din      <= 8'd0;
            rf_constant <= 8'd0;
            done        <= 1'b0;
            err         <= 1'b0;
            store_q     <= 1'b0;
            upd_q       <= 1'b0;
            delta_q     <= 8'd0;
            wait_cnt    <= 8'd0;
        end else begin
            done        <= 1'b0;
            rf_write_en <= 1'b0;
            rf_add      <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        mem_addr  <= {addr_hi, addr_lo};
                        mem_wdata <= store_data;
                        mem_we    <= op_store;
                        store_q   <= op_store;
                        upd_q     <= op_ptr_update;
                        delta_q   <= op_ptr_delta;
                        err       <= 1'b0;
                        wait_cnt  <= 8'd0;
                        mem_req   <= 1'b1;
                        op_ready  <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // An ack always wins, even in the cycle the wait counter would expire.
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        done        <= 1'b1;
                        rf_write_en <= !store_q;
                        rf_add      <= upd_q;
                        if (!store_q) begin
                            rf_din <= mem_rdata;
                        end
                        if (upd_q) begin
                            rf_constant <= delta_q;
                        end
                        state <= WB;
                    end else begin
                        wait_cnt <= wait_next;
                        if (wait_next == LIMIT) begin
                            mem_req  <= 1'b0;
                            mem_we   <= 1'b0;
                            err      <= 1'b1;
                            op_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                WB: begin
                    op_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    op_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a scoreboard of expected writebacks on the main
// instance, plus a short-timeout instance for the abort and ack-at-limit cases.
module tb_lsu_ctrl;

    typedef struct {
        logic       wen;
        logic [7:0] din;
        logic       add;
        logic [7:0] cst;
    } wb_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       op_store, op_ptr_update;
    logic [7:0] op_ptr_delta, addr_lo, addr_hi, store_data, mem_rdata;
    logic       op_valid_a, mem_ack_a, op_valid_b, mem_ack_b;

    logic        op_ready_a, mem_req_a, mem_we_a, rf_write_en_a, rf_add_a, done_a, err_a;
    logic [15:0] mem_addr_a;
    logic [7:0]  mem_wdata_a, rf_din_a, rf_constant_a;
    logic        op_ready_b, mem_req_b, mem_we_b, rf_write_en_b, rf_add_b, done_b, err_b;
    logic [15:0] mem_addr_b;
    logic [7:0]  mem_wdata_b, rf_din_b, rf_constant_b;

    int   n_compared = 0;
    int   n_mismatched = 0;
    wb_t  exp_q[$];
    wb_t  exp_item;
    logic [7:0] last_din = 8'd0;
    logic [7:0] last_cst = 8'd0;

    always #5 clk = ~clk;

    lsu_ctrl u_dut_a (
        .clk(clk), .reset(reset), .op_valid(op_valid_a), .op_store(op_store),
        .op_ptr_update(op_ptr_update), .op_ptr_delta(op_ptr_delta),
        .addr_lo(addr_lo), .addr_hi(addr_hi), .store_data(store_data),
        .op_ready(op_ready_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_ack(mem_ack_a), .mem_rdata(mem_rdata),
        .rf_write_en(rf_write_en_a), .rf_add(rf_add_a), .rf_din(rf_din_a),
        .rf_constant(rf_constant_a), .done(done_a), .err(err_a)
    );

    lsu_ctrl #(.WAIT_LIMIT(4)) u_dut_b (
        .clk(clk), .reset(reset), .op_valid(op_valid_b), .op_store(op_store),
        .op_ptr_update(op_ptr_update), .op_ptr_delta(op_ptr_delta),
        .addr_lo(addr_lo), .addr_hi(addr_hi), .store_data(store_data),
        .op_ready(op_ready_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ack(mem_ack_b), .mem_rdata(mem_rdata),
        .rf_write_en(rf_write_en_b), .rf_add(rf_add_b), .rf_din(rf_din_b),
        .rf_constant(rf_constant_b), .done(done_b), .err(err_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Predicts the writeback of one op; rf_din/rf_constant keep their old value when not written.
    task automatic pushExpected(input logic store, input logic upd, input logic [7:0] delta, input logic [7:0] rdata);
        wb_t e;
        e.wen = !store;
        e.din = store ? last_din : rdata;
        e.add = upd;
        e.cst = upd ? delta : last_cst;
        last_din = e.din;
        last_cst = e.cst;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic store, input logic upd, input logic [7:0] delta,
                                 input logic [15:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] rdata, input bit expect_wb);
        op_valid_a    = 1'b1;
        op_store      = store;
        op_ptr_update = upd;
        op_ptr_delta  = delta;
        addr_hi       = addr[15:8];
        addr_lo       = addr[7:0];
        store_data    = wdata;
        if (expect_wb) pushExpected(store, upd, delta, rdata);
    endtask

    // Scoreboard monitor for the main instance.
    always @(posedge clk) begin
        #1;
        if (done_a) begin
            if (exp_q.size() == 0) begin
                checkOutput("done_unexpected", done_a, 32'd0);
            end else begin
                exp_item = exp_q.pop_front();
                checkOutput("sb_wen", rf_write_en_a, exp_item.wen);
                checkOutput("sb_din", rf_din_a, exp_item.din);
                checkOutput("sb_add", rf_add_a, exp_item.add);
                checkOutput("sb_cst", rf_constant_a, exp_item.cst);
            end
        end else begin
            checkOutput("wen_outside_wb", rf_write_en_a, 32'd0);
            checkOutput("add_outside_wb", rf_add_a, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        op_valid_a = 1'b0; mem_ack_a = 1'b0; op_valid_b = 1'b0; mem_ack_b = 1'b0;
        op_store = 1'b0; op_ptr_update = 1'b0; op_ptr_delta = 8'd0;
        addr_lo = 8'd0; addr_hi = 8'd0; store_data = 8'd0; mem_rdata = 8'd0;
        tick();
        tick();
        checkOutput("rst_ready", op_ready_a, 32'd1);
        checkOutput("rst_req", mem_req_a, 32'd0);
        checkOutput("rst_done", done_a, 32'd0);
        checkOutput("rst_err", err_a, 32'd0);
        checkOutput("rst_addr", mem_addr_a, 32'd0);
        checkOutput("rst_din", rf_din_a, 32'd0);

        // Load 0x1234 accepted on the first edge after reset release, ack at N+1.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h1234, 8'h00, 8'hA5, 1'b1);
        tick();
        op_valid_a = 1'b0;
        checkOutput("ld_req", mem_req_a, 32'd1);
        checkOutput("ld_addr", mem_addr_a, 32'h1234);
        checkOutput("ld_we", mem_we_a, 32'd0);
        checkOutput("ld_ready_busy", op_ready_a, 32'd0);
        mem_ack_a = 1'b1;
        mem_rdata = 8'hA5;
        tick();
        mem_ack_a = 1'b0;
        checkOutput("ld_done", done_a, 32'd1);
        checkOutput("ld_wen", rf_write_en_a, 32'd1);
        checkOutput("ld_din", rf_din_a, 32'hA5);
        tick();
        checkOutput("ld_ready_after", op_ready_a, 32'd1);
        checkOutput("ld_done_pulse", done_a, 32'd0);

        // Store 0x3C to 0x00FF with pointer update; ack after four wait cycles.
        applyStimulus(1'b1, 1'b1, 8'h02, 16'h00FF, 8'h3C, 8'h00, 1'b1);
        tick();
        op_valid_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("st_req", mem_req_a, 32'd1);
            checkOutput("st_we", mem_we_a, 32'd1);
            checkOutput("st_wdata", mem_wdata_a, 32'h3C);
            checkOutput("st_addr", mem_addr_a, 32'h00FF);
            addr_hi = 8'hDE; addr_lo = 8'hAD; store_data = 8'h99;
            if (i == 4) mem_ack_a = 1'b1;
            tick();
        end
        mem_ack_a = 1'b0;
        checkOutput("st_done", done_a, 32'd1);
        checkOutput("st_add", rf_add_a, 32'd1);
        checkOutput("st_cst", rf_constant_a, 32'h02);
        checkOutput("st_wen", rf_write_en_a, 32'd0);
        checkOutput("st_req_off", mem_req_a, 32'd0);
        tick();

        // Short-limit instance: load never acknowledged, then ack exactly at the limit.
        op_store = 1'b0; op_ptr_update = 1'b0;
        op_valid_b = 1'b1;
        tick();
        op_valid_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("to_req_high", mem_req_b, 32'd1);
            checkOutput("to_no_done", done_b, 32'd0);
            tick();
        end
        checkOutput("to_req_low", mem_req_b, 32'd0);
        checkOutput("to_err", err_b, 32'd1);
        checkOutput("to_ready", op_ready_b, 32'd1);
        checkOutput("to_no_done_end", done_b, 32'd0);
        checkOutput("to_no_wen", rf_write_en_b, 32'd0);
        op_valid_b = 1'b1;
        tick();
        op_valid_b = 1'b0;
        checkOutput("to_err_cleared", err_b, 32'd0);
        checkOutput("to_req_again", mem_req_b, 32'd1);
        tick();
        tick();
        tick();
        mem_ack_b = 1'b1;
        mem_rdata = 8'h5A;
        tick();
        mem_ack_b = 1'b0;
        checkOutput("lim_done", done_b, 32'd1);
        checkOutput("lim_err", err_b, 32'd0);
        checkOutput("lim_wen", rf_write_en_b, 32'd1);
        checkOutput("lim_din", rf_din_b, 32'h5A);
        tick();

        // op_valid held high with ack always present: one accept every third cycle.
        op_store = 1'b0; op_ptr_update = 1'b0;
        op_valid_a = 1'b1;
        mem_ack_a = 1'b1;
        for (int k = 0; k < 9; k++) begin
            checkOutput("cont_ready", op_ready_a, (k % 3 == 0) ? 32'd1 : 32'd0);
            if (k % 3 == 1) begin
                checkOutput("cont_req", mem_req_a, 32'd1);
                checkOutput("cont_addr", mem_addr_a, 32'h2000 + 32'(k - 1));
            end
            addr_hi = 8'h20;
            addr_lo = 8'(k);
            mem_rdata = 8'h40 + 8'(k);
            if (k % 3 == 0) pushExpected(1'b0, 1'b0, 8'h00, 8'h40 + 8'(k + 1));
            tick();
        end
        op_valid_a = 1'b0;
        mem_ack_a = 1'b0;
        checkOutput("cont_idle", op_ready_a, 32'd1);

        // Reset in the second REQ cycle; the op is dropped and the late ack ignored.
        applyStimulus(1'b0, 1'b1, 8'h07, 16'hBEEF, 8'h00, 8'h00, 1'b0);
        tick();
        op_valid_a = 1'b0;
        tick();
        checkOutput("rr_req_before", mem_req_a, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rr_req_async", mem_req_a, 32'd0);
        checkOutput("rr_ready_async", op_ready_a, 32'd1);
        checkOutput("rr_addr_async", mem_addr_a, 32'd0);
        checkOutput("rr_cst_async", rf_constant_a, 32'd0);
        last_din = 8'd0;
        last_cst = 8'd0;
        mem_ack_a = 1'b1;
        mem_rdata = 8'hEE;
        tick();
        reset = 1'b1;
        tick();
        mem_ack_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rr_no_done", done_a, 32'd0);
            checkOutput("rr_no_wen", rf_write_en_a, 32'd0);
            tick();
        end

        checkOutput("sb_pending", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
